multicycle_datapath: RTL and testbench
======================================

Name: multicycle_datapath

Overview:
Parametrised multi-cycle RV32I-subset core datapath with its own control FSM. It replaces the single-cycle datapath plus separate decoder.
- One unified memory port with a valid/ready handshake, shared by fetch and load/store.
- The architectural register file stays external; it is reached through read/write ports.
- Internal non-architectural registers: PC, OldPC, IR, Data, A, B, ALUOut. This lets one memory and one ALU be reused across cycles.

Parameters:
XLEN, 32, datapath width (only 32 supported for RV32I decode)
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 32, width of performance counters (used only with PERF_CNT_EN)

Ports:
clk  in  1  clock, all state updates on rising edge
Reset  in  1  synchronous, active-high reset
mem_req  out  1  memory request valid
mem_we  out  1  1 = write, 0 = read; meaningful only with mem_req
mem_addr  out  XLEN  byte address (word-aligned)
mem_wdata  out  XLEN  store data
mem_rdata  in  XLEN  read data, sampled when mem_req & mem_ready
mem_ready  in  1  memory completes the transfer this cycle
rf_ra1  out  5  = IR[19:15]
rf_ra2  out  5  = IR[24:20]
rf_rd1  in  XLEN  register read data 1 (combinational regfile)
rf_rd2  in  XLEN  register read data 2
rf_wa  out  5  = IR[11:7]
rf_wd  out  XLEN  writeback data
rf_we  out  1  writeback enable
PC  out  XLEN  current PC register
illegal  out  1  sticky illegal-instruction flag
cycle_count  out  CNT_W  cycles since reset (0 without PERF_CNT_EN)
instret  out  CNT_W  retired instructions (0 without PERF_CNT_EN)

Behaviour:
- Reset (synchronous, dominates everything):
  - state=FETCH, PC=RESET_PC, OldPC=0, IR=32'h0000_0013, A=B=ALUOut=Data=0, illegal=0, counters=0.
  - While Reset=1, mem_req, mem_we and rf_we are forced 0. Any in-flight memory transfer is abandoned.
- Supported instructions: lw, sw, R-type (add, sub, and, or, xor, slt, sll, srl, sra), I-ALU (addi, andi, ori, xori, slti, slli, srli, srai), beq, bne, jal, lui. Anything else goes to ILLEGAL.
- Internal ALU: add, sub, and, or, xor, slt (signed), sll, srl, sra; shift amount is b[4:0]. Immediates: I, S, B, J, U formats, sign-extended to XLEN.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=PC.
  - Holds until mem_ready. On ready: IR<=mem_rdata, OldPC<=PC, PC<=PC+4, then DECODE.
- DECODE: A<=rf_rd1, B<=rf_rd2, ALUOut<=OldPC+immB/J (branch/jump target). Next state by opcode:
  - lw/sw -> MEMADR
  - R-type -> EXEC_R
  - I-ALU -> EXEC_I
  - beq/bne -> BRANCH
  - jal -> JAL
  - lui -> LUI
  - other -> ILLEGAL
- MEMADR: ALUOut<=A+imm(I for lw, S for sw); then MEMRD or MEMWR.
- MEMRD: mem_req=1, mem_addr=ALUOut. Waits for mem_ready; on ready Data<=mem_rdata, then MEMWB.
- MEMWB: rf_wd=Data, rf_we=1; then FETCH.
- MEMWR: mem_req=1, mem_we=1, mem_addr=ALUOut, mem_wdata=B. Waits for mem_ready, then FETCH.
- EXEC_R / EXEC_I: ALUOut<=A op B / A op imm; then ALUWB.
- ALUWB: rf_wd=ALUOut, rf_we=1; then FETCH.
- BRANCH: if (A==B) xor funct3[0], PC<=ALUOut; then FETCH. funct3 other than 000/001 -> ILLEGAL.
- JAL: PC<=ALUOut, ALUOut<=OldPC+4; then ALUWB.
- LUI: ALUOut<={IR[31:12],12'b0}; then ALUWB.
- ILLEGAL: illegal=1, terminal until Reset; no memory or regfile activity.
- rf_we is suppressed whenever rf_wa==0.
- Handshake rules:
  - mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and mem_ready=0.
  - mem_ready while mem_req=0 is ignored.
- Latency with zero-wait memory (mem_ready tied 1):
  - lw 5 cycles
  - sw, R, I, jal, lui 4 cycles
  - beq/bne 3 cycles
  - Each memory wait cycle adds one.
- PC wraps modulo 2^XLEN; no alignment checks.

Optional Feature:
PERF_CNT_EN:
- Defined:
  - cycle_count increments every non-reset cycle.
  - instret increments on the last cycle of each retiring instruction: FETCH entry from MEMWB, MEMWR (ready), ALUWB or BRANCH.
  - Both counters wrap at 2^CNT_W.
- Undefined: both outputs tied to 0 and the counter registers are not built.

Test Plan:
- Reset with RESET_PC=32'h100 -> first mem_addr=32'h100, mem_req=1 on the cycle after Reset falls; PC=32'h100.
- addi x1,x0,5 then add x2,x1,x1 (zero-wait) -> rf_we in ALUWB with rf_wa=1/rf_wd=5, then rf_wa=2/rf_wd=10; 4 cycles each.
- sw x2,8(x0) with mem_ready low for 3 cycles -> mem_req=1, mem_we=1, mem_addr=8, mem_wdata=10 held stable for 4 cycles; then lw x3,8(x0) -> rf_wd=10 in MEMWB.
- beq x1,x1,-8 at PC=0x20 -> PC=0x18 after 3 cycles; bne x1,x1 at 0x20 -> PC=0x24.
- jal x1,+16 at 0x40 -> PC=0x50, rf_wa=1, rf_wd=0x44; addi x0,x0,1 -> rf_we stays 0.
- Opcode 7'h7F fetched -> illegal=1, mem_req stays 0 until Reset; with PERF_CNT_EN, instret is unchanged by the illegal instruction.

Source files
------------

// File: rtl/multicycle_datapath.sv
// multicycle_datapath: multi-cycle RV32I-subset core datapath with its own
// control FSM. A single memory port (valid/ready) serves both instruction
// fetch and load/store; one ALU is reused across cycles through the
// non-architectural registers PC, OldPC, IR, Data, A, B and ALUOut.
// The architectural register file is external and combinational.
// Optional feature macro: PERF_CNT_EN builds the cycle/instret counters;
// without it cycle_count and instret are tied to zero.
module multicycle_datapath #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             Reset,
    output logic             mem_req,
    output logic             mem_we,
    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_wdata,
    input  logic [XLEN-1:0]  mem_rdata,
    input  logic             mem_ready,
    output logic [4:0]       rf_ra1,
    output logic [4:0]       rf_ra2,
    input  logic [XLEN-1:0]  rf_rd1,
    input  logic [XLEN-1:0]  rf_rd2,
    output logic [4:0]       rf_wa,
    output logic [XLEN-1:0]  rf_wd,
    output logic             rf_we,
    output logic [XLEN-1:0]  PC,
    output logic             illegal,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret
);

    // Control FSM states
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXEC_R  = 4'd6;
    localparam logic [3:0] S_EXEC_I  = 4'd7;
    localparam logic [3:0] S_ALUWB   = 4'd8;
    localparam logic [3:0] S_BRANCH  = 4'd9;
    localparam logic [3:0] S_JAL     = 4'd10;
    localparam logic [3:0] S_LUI     = 4'd11;
    localparam logic [3:0] S_ILLEGAL = 4'd12;

    // Major opcodes of the supported subset
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [XLEN-1:0] WORD_BYTES = XLEN'(32'd4);
    localparam logic [XLEN-1:0] NOP_INSTR  = XLEN'(32'h0000_0013);

    logic [3:0]      state_r;
    logic [3:0]      next_state_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] old_pc_r;
    logic [XLEN-1:0] ir_r;
    logic [XLEN-1:0] data_r;
    logic [XLEN-1:0] a_r;
    logic [XLEN-1:0] b_r;
    logic [XLEN-1:0] alu_out_r;
    logic            illegal_r;

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic [XLEN-1:0] imm_i_s;
    logic [XLEN-1:0] imm_s_s;
    logic [XLEN-1:0] imm_b_s;
    logic [XLEN-1:0] imm_j_s;
    logic [XLEN-1:0] imm_u_s;
    logic            r_legal_s;
    logic            i_legal_s;
    logic            br_legal_s;
    logic            br_taken_s;
    logic [3:0]      alu_op_s;
    logic [XLEN-1:0] alu_b_s;
    logic [XLEN-1:0] alu_result_s;

    // ALU: op = {alt, funct3}; alt selects sub / sra. Shift amount is b[4:0].
    function automatic logic [XLEN-1:0] alu_fn(input logic [3:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        logic [XLEN-1:0] res;
        case (op)
            4'b0000: res = a + b;
            4'b1000: res = a - b;
            4'b0001: res = a << b[4:0];
            4'b0010: res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b0100: res = a ^ b;
            4'b0101: res = a >> b[4:0];
            4'b1101: res = $signed(a) >>> b[4:0];
            4'b0110: res = a | b;
            4'b0111: res = a & b;
            default: res = {XLEN{1'b0}};
        endcase
        return res;
    endfunction

    assign opcode_s = ir_r[6:0];
    assign funct3_s = ir_r[14:12];
    assign funct7_s = ir_r[31:25];
    assign imm_i_s  = {{(XLEN-12){ir_r[31]}}, ir_r[31:20]};
    assign imm_s_s  = {{(XLEN-12){ir_r[31]}}, ir_r[31:25], ir_r[11:7]};
    assign imm_b_s  = {{(XLEN-12){ir_r[31]}}, ir_r[7], ir_r[30:25], ir_r[11:8], 1'b0};
    assign imm_j_s  = {{(XLEN-20){ir_r[31]}}, ir_r[19:12], ir_r[20], ir_r[30:21], 1'b0};
    assign imm_u_s  = {{(XLEN-31){ir_r[31]}}, ir_r[30:12], 12'h000};

    // Legality of funct3/funct7 combinations inside the R, I and branch groups
    always_comb begin
        r_legal_s  = 1'b0;
        i_legal_s  = 1'b0;
        br_legal_s = (funct3_s[2:1] == 2'b00);
        if (funct3_s == 3'b011) begin
            r_legal_s = 1'b0;
            i_legal_s = 1'b0;
        end else begin
            r_legal_s = (funct7_s == 7'h00) ||
                        ((funct7_s == 7'h20) && ((funct3_s == 3'b000) || (funct3_s == 3'b101)));
            if (funct3_s == 3'b001) begin
                i_legal_s = (funct7_s == 7'h00);
            end else if (funct3_s == 3'b101) begin
                i_legal_s = (funct7_s == 7'h00) || (funct7_s == 7'h20);
            end else begin
                i_legal_s = 1'b1;
            end
        end
    end

    // ALU operand/operation select for the two execute states
    always_comb begin
        if (state_r == S_EXEC_R) begin
            alu_op_s = {ir_r[30], funct3_s};
            alu_b_s  = b_r;
        end else begin
            alu_op_s = {(funct3_s == 3'b101) & ir_r[30], funct3_s};
            alu_b_s  = imm_i_s;
        end
        alu_result_s = alu_fn(alu_op_s, a_r, alu_b_s);
        br_taken_s   = (a_r == b_r) ^ funct3_s[0];
    end

    // Next-state logic of the control FSM
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_FETCH:  next_state_s = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode_s)
                    OP_LOAD:  next_state_s = (funct3_s == 3'b010) ? S_MEMADR : S_ILLEGAL;
                    OP_STORE: next_state_s = (funct3_s == 3'b010) ? S_MEMADR : S_ILLEGAL;
                    OP_R:     next_state_s = r_legal_s ? S_EXEC_R : S_ILLEGAL;
                    OP_I:     next_state_s = i_legal_s ? S_EXEC_I : S_ILLEGAL;
                    OP_BR:    next_state_s = S_BRANCH;
                    OP_JAL:   next_state_s = S_JAL;
                    OP_LUI:   next_state_s = S_LUI;
                    default:  next_state_s = S_ILLEGAL;
                endcase
            end
            S_MEMADR: next_state_s = (opcode_s == OP_STORE) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  next_state_s = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  next_state_s = S_FETCH;
            S_MEMWR:  next_state_s = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC_R: next_state_s = S_ALUWB;
            S_EXEC_I: next_state_s = S_ALUWB;
            S_ALUWB:  next_state_s = S_FETCH;
            S_BRANCH: next_state_s = br_legal_s ? S_FETCH : S_ILLEGAL;
            S_JAL:    next_state_s = S_ALUWB;
            S_LUI:    next_state_s = S_ALUWB;
            S_ILLEGAL: next_state_s = S_ILLEGAL;
            default:  next_state_s = S_ILLEGAL;
        endcase
    end

    // State register and internal datapath registers
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_r   <= S_FETCH;
            pc_r      <= RESET_PC;
            old_pc_r  <= {XLEN{1'b0}};
            ir_r      <= NOP_INSTR;
            data_r    <= {XLEN{1'b0}};
            a_r       <= {XLEN{1'b0}};
            b_r       <= {XLEN{1'b0}};
            alu_out_r <= {XLEN{1'b0}};
            illegal_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (next_state_s == S_ILLEGAL) begin
                illegal_r <= 1'b1;
            end
            case (state_r)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir_r     <= mem_rdata;
                        old_pc_r <= pc_r;
                        pc_r     <= pc_r + WORD_BYTES;
                    end
                end
                S_DECODE: begin
                    a_r       <= rf_rd1;
                    b_r       <= rf_rd2;
                    alu_out_r <= old_pc_r + ((opcode_s == OP_JAL) ? imm_j_s : imm_b_s);
                end
                S_MEMADR: alu_out_r <= a_r + ((opcode_s == OP_STORE) ? imm_s_s : imm_i_s);
                S_MEMRD: begin
                    if (mem_ready) begin
                        data_r <= mem_rdata;
                    end
                end
                S_EXEC_R: alu_out_r <= alu_result_s;
                S_EXEC_I: alu_out_r <= alu_result_s;
                S_BRANCH: begin
                    if (br_legal_s && br_taken_s) begin
                        pc_r <= alu_out_r;
                    end
                end
                S_JAL: begin
                    pc_r      <= alu_out_r;
                    alu_out_r <= old_pc_r + WORD_BYTES;
                end
                S_LUI: alu_out_r <= imm_u_s;
                default: ;
            endcase
        end
    end

    // Memory and register-file port decode; Reset masks all requests/enables
    always_comb begin
        mem_req   = ~Reset & ((state_r == S_FETCH) || (state_r == S_MEMRD) || (state_r == S_MEMWR));
        mem_we    = ~Reset & (state_r == S_MEMWR);
        mem_addr  = (state_r == S_FETCH) ? pc_r : alu_out_r;
        mem_wdata = b_r;
        rf_ra1    = ir_r[19:15];
        rf_ra2    = ir_r[24:20];
        rf_wa     = ir_r[11:7];
        rf_wd     = (state_r == S_MEMWB) ? data_r : alu_out_r;
        rf_we     = ~Reset & ((state_r == S_MEMWB) || (state_r == S_ALUWB)) & (ir_r[11:7] != 5'd0);
        PC        = pc_r;
        illegal   = illegal_r;
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_r;
    logic [CNT_W-1:0] instret_r;
    logic             retire_s;

    // An instruction retires on its last cycle before returning to FETCH
    always_comb begin
        retire_s = (state_r == S_MEMWB) || (state_r == S_ALUWB) ||
                   ((state_r == S_MEMWR) && mem_ready) ||
                   ((state_r == S_BRANCH) && br_legal_s);
    end

    // Free-running performance counters, wrapping at 2^CNT_W
    always_ff @(posedge clk) begin
        if (Reset) begin
            cycle_cnt_r <= {CNT_W{1'b0}};
            instret_r   <= {CNT_W{1'b0}};
        end else begin
            cycle_cnt_r <= cycle_cnt_r + CNT_W'(1'b1);
            if (retire_s) begin
                instret_r <= instret_r + CNT_W'(1'b1);
            end
        end
    end

    assign cycle_count = cycle_cnt_r;
    assign instret     = instret_r;
`else
    assign cycle_count = {CNT_W{1'b0}};
    assign instret     = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_multicycle_datapath.sv
// Self-checking bench for multicycle_datapath. The bench plays memory and
// register file; an instruction-level model predicts, per instruction, the
// exact cycle-by-cycle bus/writeback activity from the ISA rules and the
// documented latencies, and every cycle is compared against it.
module tb_multicycle_datapath;

    localparam logic [31:0] RPC   = 32'h0000_0100;
    localparam logic [6:0]  OPR   = 7'b0110011;
    localparam logic [6:0]  OPI   = 7'b0010011;
    localparam logic [6:0]  OPL   = 7'b0000011;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [4:0]  rf_ra1, rf_ra2, rf_wa;
    logic [31:0] rf_rd1, rf_rd2, rf_wd, PC;
    logic        rf_we, illegal;
    logic [31:0] cycle_count, instret;

    always #5 clk = ~clk;

    multicycle_datapath #(.XLEN(32), .RESET_PC(RPC), .CNT_W(32)) dut (
        .clk(clk), .Reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_we(rf_we),
        .PC(PC), .illegal(illegal), .cycle_count(cycle_count), .instret(instret)
    );

    // Model state
    logic [31:0] mregs [32];
    logic [31:0] mpc;
    logic [31:0] dmem [logic [31:0]];
    int          ncyc, retired;
    int          checks = 0, errors = 0;
    logic [31:0] last_wr_addr, last_wr_data;
    int          wr_cycles;

    // External register file driven by the DUT, preloaded from the model during reset
    logic [31:0] regs [32];
    assign rf_rd1 = regs[rf_ra1];
    assign rf_rd2 = regs[rf_ra2];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= mregs[i];
        end else if (rf_we) begin
            regs[rf_wa] <= rf_wd;
        end
    end

    typedef struct {
        logic        req; logic we; logic [31:0] addr; logic [31:0] wdata;
        logic        ready; logic [31:0] rdata;
        logic        wb; logic [4:0] wa; logic [31:0] wd; logic ill;
    } cyc_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic cyc_t mk(input logic req, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic ready, input logic [31:0] rdata,
                                input logic wb, input logic [4:0] wa, input logic [31:0] wd,
                                input logic ill);
        cyc_t c;
        c.req = req; c.we = we; c.addr = addr; c.wdata = wdata; c.ready = ready;
        c.rdata = rdata; c.wb = wb; c.wa = wa; c.wd = wd; c.ill = ill;
        return c;
    endfunction

    // ISA semantics of the ALU operations
    function automatic logic [31:0] m_alu(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b & 32'd31);
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: begin
                if (alt) return 32'($signed(a) >>> sh);
                else     return a >> sh;
            end
            3'd6: return a | b;
            3'd7: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OPR};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    // Random legal instruction over x0..x7
    function automatic logic [31:0] gen();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [12:0] bimm;
        logic [20:0] jimm;
        rd = 5'($urandom_range(0, 7)); rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
        f3 = 3'($urandom_range(0, 7)); if (f3 == 3'd3) f3 = 3'd0;
        imm = 12'($urandom); bimm = 13'($urandom); bimm[0] = 1'b0;
        jimm = 21'($urandom); jimm[0] = 1'b0;
        case ($urandom_range(0, 7))
            0: return enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                            rs2, rs1, f3, rd);
            1, 7: begin
                if (f3 == 3'd1) imm[11:5] = 7'h00;
                if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                return enc_i(imm, rs1, f3, rd, OPI);
            end
            2: return enc_i(imm, rs1, 3'b010, rd, OPL);
            3: return enc_s(imm, rs2, rs1);
            4: return enc_b(bimm, rs2, rs1, {2'b00, f3[0]});
            5: return enc_j(jimm, rd);
            default: return {20'($urandom), rd, 7'b0110111};
        endcase
    endfunction

    // Predict and check one instruction: fw fetch waits, mw data waits
    task automatic run_instr(input logic [31:0] ir, input int fw, input int mw);
        cyc_t        q[$];
        cyc_t        c;
        logic [31:0] a, b, npc, val, addr, ii, is, ib, ij;
        logic [4:0]  rd;
        logic [2:0]  f3;
        bit          ill, has_wb;
        a = mregs[ir[19:15]]; b = mregs[ir[24:20]]; rd = ir[11:7]; f3 = ir[14:12];
        ii = 32'($signed(ir[31:20]));
        is = 32'($signed({ir[31:25], ir[11:7]}));
        ib = 32'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
        ij = 32'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
        npc = mpc + 32'd4; ill = 1'b0; has_wb = 1'b0; val = 32'd0; wr_cycles = 0;
        for (int i = 0; i <= fw; i++) q.push_back(mk(1'b1, 1'b0, mpc, 32'd0, i == fw, ir, 1'b0, 5'd0, 32'd0, 1'b0));
        q.push_back(mk(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0));
        case (ir[6:0])
            OPR: begin val = m_alu(f3, ir[30], a, b); has_wb = 1'b1; end
            OPI: begin val = m_alu(f3, (f3 == 3'd5) && ir[30], a, ii); has_wb = 1'b1; end
            OPL: begin
                addr = a + ii;
                if (!dmem.exists(addr)) dmem[addr] = $urandom;
                val = dmem[addr]; has_wb = 1'b1;
                q.push_back(mk(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0));
                for (int i = 0; i <= mw; i++) q.push_back(mk(1'b1, 1'b0, addr, 32'd0, i == mw, val, 1'b0, 5'd0, 32'd0, 1'b0));
            end
            7'b0100011: begin
                addr = a + is;
                q.push_back(mk(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0));
                for (int i = 0; i <= mw; i++) q.push_back(mk(1'b1, 1'b1, addr, b, i == mw, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0));
                dmem[addr] = b;
            end
            7'b1100011: begin
                if ((a == b) ^ ir[12]) npc = mpc + ib;
                q.push_back(mk(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0));
            end
            7'b1101111: begin val = mpc + 32'd4; npc = mpc + ij; has_wb = 1'b1; end
            7'b0110111: begin val = {ir[31:12], 12'h000}; has_wb = 1'b1; end
            default: begin
                ill = 1'b1;
                for (int i = 0; i < 12; i++) q.push_back(mk(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1));
            end
        endcase
        if (has_wb) begin
            if (ir[6:0] == OPR || ir[6:0] == OPI || ir[6:0] == 7'b1101111 || ir[6:0] == 7'b0110111)
                q.push_back(mk(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0));
            q.push_back(mk(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, rd != 5'd0, rd, val, 1'b0));
        end
        for (int k = 0; k < q.size(); k++) begin
            #1;
            c = q[k];
            if (k == 0) chk("pc", PC, mpc);
            chk("mem_req", {31'd0, mem_req}, {31'd0, c.req});
            if (c.req) begin
                chk("mem_we", {31'd0, mem_we}, {31'd0, c.we});
                chk("mem_addr", mem_addr, c.addr);
                if (c.we) begin
                    chk("mem_wdata", mem_wdata, c.wdata);
                    last_wr_addr = mem_addr; last_wr_data = mem_wdata; wr_cycles++;
                end
            end
            chk("rf_we", {31'd0, rf_we}, {31'd0, c.wb});
            if (c.wb) begin
                chk("rf_wa", {27'd0, rf_wa}, {27'd0, c.wa});
                chk("rf_wd", rf_wd, c.wd);
            end
            chk("illegal", {31'd0, illegal}, {31'd0, c.ill});
`ifdef PERF_CNT_EN
            chk("cycle_count", cycle_count, 32'(ncyc));
            chk("instret", instret, 32'(retired));
`else
            if (k == 0) begin
                chk("cycle_count_off", cycle_count, 32'd0);
                chk("instret_off", instret, 32'd0);
            end
`endif
            mem_ready = c.req ? c.ready : 1'($urandom_range(0, 1));
            mem_rdata = c.req ? c.rdata : $urandom;
            @(negedge clk);
            ncyc++;
        end
        if (has_wb && rd != 5'd0) mregs[rd] = val;
        mpc = npc;
        if (!ill) retired++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b1; mem_rdata = $urandom;
            @(negedge clk); #1;
            chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
            chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
            chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        end
        chk("rst_pc", PC, RPC);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_cycle_count", cycle_count, 32'd0);
        chk("rst_instret", instret, 32'd0);
        @(negedge clk);
        reset = 1'b0; mpc = RPC; ncyc = 0; retired = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; mem_ready = 1'b0; mem_rdata = 32'd0;
        mregs[0] = 32'd0;
        for (int i = 1; i < 32; i++) mregs[i] = $urandom;
        do_reset();

        // Directed program with hand-computed expectations
        run_instr(enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI), 0, 0);
        chk("pin_addi_x1", regs[1], 32'd5);
        run_instr(enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd2), 0, 0);
        chk("pin_add_x2", regs[2], 32'd10);
        run_instr(enc_s(12'd8, 5'd2, 5'd0), 0, 3);
        chk("pin_sw_addr", last_wr_addr, 32'd8);
        chk("pin_sw_data", last_wr_data, 32'd10);
        chk("pin_sw_hold", 32'(wr_cycles), 32'd4);
        run_instr(enc_i(12'd8, 5'd0, 3'b010, 5'd3, OPL), 0, 0);
        chk("pin_lw_x3", regs[3], 32'd10);
        run_instr(enc_j(21'h1F_FF10, 5'd0), 0, 0);
        chk("pin_jal_back", PC, 32'h20);
        run_instr(enc_b(13'h1FF8, 5'd1, 5'd1, 3'b000), 0, 0);
        chk("pin_beq", PC, 32'h18);
        run_instr(enc_j(21'd8, 5'd0), 0, 0);
        run_instr(enc_b(13'd8, 5'd1, 5'd1, 3'b001), 0, 0);
        chk("pin_bne", PC, 32'h24);
        run_instr(enc_j(21'h1C, 5'd0), 0, 0);
        run_instr(enc_j(21'd16, 5'd1), 0, 0);
        chk("pin_jal_pc", PC, 32'h50);
        chk("pin_jal_link", regs[1], 32'h44);
        run_instr(enc_i(12'd1, 5'd0, 3'b000, 5'd0, OPI), 0, 0);
        chk("pin_x0", regs[0], 32'd0);

        // Randomized instruction stream with random wait states
        for (int n = 0; n < 200; n++) begin
            run_instr(gen(), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Illegal opcode: sticky flag, no further bus activity
        run_instr(32'h0000_007F, 1, 0);
        chk("ill_sticky", {31'd0, illegal}, 32'd1);
        chk("ill_no_req", {31'd0, mem_req}, 32'd0);

        do_reset();
        run_instr(enc_i(12'h7FF, 5'd0, 3'b110, 5'd4, OPI), 0, 0);
        chk("pin_ori_after_reset", regs[4], 32'h0000_07FF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
